vga_capture: RTL
================

# vga_capture

Receive-side counterpart of the VGA timing generator: samples an incoming VGA pixel stream (active-low `h_sync`/`v_sync`, `blank` high during active video, 8-bit RGB) and writes each active pixel into a frame buffer at a linear address. It checks frame geometry and reports `locked` once a complete, well-formed frame has been captured. The capture path loops a generator's output back into a buffer, and also serves as the input stage of external-video capture.

## Interface

Parameters:

- `VIEW_WIDTH`, 640, active pixels per line
- `VIEW_HEIGHT`, 480, active lines per frame
- `ADDR_WIDTH`, 19, write-address width; must satisfy VIEW_WIDTH*VIEW_HEIGHT <= 2**ADDR_WIDTH

Ports:

- `clock`  in  1  pixel clock; all inputs are synchronous to it
- `reset`  in  1  asynchronous, active-low reset
- `h_sync`  in  1  horizontal sync, active low
- `v_sync`  in  1  vertical sync, active low
- `blank`  in  1  high during active video
- `red`, `green`, `blue`  in  8 each  pixel colour
- `write_enable`  out  1  frame-buffer write strobe
- `write_address`  out  ADDR_WIDTH  linear address, line*VIEW_WIDTH + pixel
- `write_data`  out  24  {red, green, blue}
- `frame_done`  out  1  one-cycle pulse after the last pixel of a good frame
- `locked`  out  1  high after one complete good frame; cleared on any error
- `error`  out  1  one-cycle pulse on a geometry violation

## Operation

- Input stage: all inputs are registered once (`_q`). Edges are detected on the registered values.
  - Frame start (FS): falling edge of `v_sync_q`.
  - Line start (LS): rising edge of `blank_q`.
  - Line end (LE): falling edge of `blank_q`.
- Counters:
  - `pixel`, width $clog2(VIEW_WIDTH+1).
  - `line`, width $clog2(VIEW_HEIGHT+1).
  - `addr`, ADDR_WIDTH; increments by 1 per write and is cleared on FS, with no multiplier.
  - `hs_seen` flag: set when `h_sync_q` is low, cleared at LS.
- States:
  - SEEK (reset state): ignores video.
    - FS → WAIT_ACTIVE with pixel, line and addr cleared.
  - WAIT_ACTIVE: waits for active video.
    - LS → CAPTURE.
    - FS → clear counters and stay.
  - CAPTURE: each cycle with `blank_q`=1 and pixel < VIEW_WIDTH → write {addr, rgb_q}, then pixel++ and addr++.
    - Pixels with pixel >= VIEW_WIDTH are not written.
    - LE with pixel == VIEW_WIDTH → line++, pixel=0.
      - If the new line == VIEW_HEIGHT: pulse `frame_done`, set `locked`, go to SEEK.
      - Otherwise go to WAIT_ACTIVE.
    - LE with pixel != VIEW_WIDTH → error.
- Error conditions. Each pulses `error`, clears `locked`, and goes to SEEK:
  - line length mismatch at LE;
  - LS in WAIT_ACTIVE with line > 0 and `hs_seen`=0;
  - FS while in CAPTURE, or in WAIT_ACTIVE with 0 < line < VIEW_HEIGHT. In this case the FS is consumed as a new frame start, so the next state is WAIT_ACTIVE with counters cleared, not SEEK.
- Simultaneous events:
  - FS and LE in the same cycle: FS takes priority. The frame restarts, the LE check is skipped, and `error` pulses only if the line was incomplete.
  - LS in the same cycle as an error: the LS is ignored.
- `locked` stays high across frames until an error or reset.

## Timing

- Reset (asynchronous, `reset`=0): `write_enable`=0, `write_address`=0, `write_data`=0, `frame_done`=0, `locked`=0, `error`=0, state SEEK, all counters 0. Deassertion is sampled synchronously.
- Latency: a pixel present on the inputs at edge N appears with `write_enable`=1 at edge N+2 (input register plus output register).
- All outputs are registered.
- `write_address` and `write_data` hold their last values while `write_enable`=0.
- `frame_done` is asserted on the cycle after the final write of the frame.
- `error` and `frame_done` are never asserted together.
- `locked` rises in the same cycle as `frame_done` and falls in the same cycle as `error`.
- Back-to-back frames are supported with zero-cycle gaps beyond the sync pulses themselves.

## Test plan

- **Reset mid-line** (VIEW_WIDTH=8, VIEW_HEIGHT=4): drop `reset` during active pixels → all outputs 0 immediately; no writes until the next FS.
- **Nominal frame**, 4 lines × 8 pixels with `h_sync` pulses between lines:
  - 32 writes at addresses 0..31, data matching the input pattern, each 2 cycles after input;
  - one `frame_done` pulse; `locked`=1.
  - A second identical frame restarts the addresses at 0, and `locked` stays 1.
- **Short line** (7 pixels on line 2): `error` pulse at LE, `locked`=0, no `frame_done`. The following good frame relocks.
- **Long line** (9 pixels): the 9th pixel is not written (last address 7 for that line), `error` pulses at LE, and the state returns to SEEK.
- **Early `v_sync` after 2 lines**: `error` pulse; the next write is at address 0; a full frame after that yields `frame_done`.
- **Active video before the first FS after reset**: no writes and no `error`. Also: a line without an intervening `h_sync` low → `error` at LS.

Source files
------------

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receive-side capture into a linear frame buffer
//
// Samples an incoming VGA pixel stream and writes every active pixel to a
// frame buffer at address line*VIEW_WIDTH + pixel (kept as a running count).
// Frame geometry is checked line by line; a complete well-formed frame pulses
// frame_done and raises locked, any geometry violation pulses error and drops
// locked.
//
// Ports:
//   clock          pixel clock, all inputs synchronous to it
//   reset          asynchronous active-low reset
//   h_sync         horizontal sync, active low
//   v_sync         vertical sync, active low
//   blank          high during active video
//   red/green/blue 8-bit pixel colour
//   write_enable   frame-buffer write strobe
//   write_address  linear pixel address (holds while write_enable is low)
//   write_data     {red, green, blue} (holds while write_enable is low)
//   frame_done     one-cycle pulse after the last write of a good frame
//   locked         high once a good frame was captured, cleared on error
//   error          one-cycle pulse on a geometry violation

module vga_capture #(
    parameter int VIEW_WIDTH  = 640,
    parameter int VIEW_HEIGHT = 480,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  h_sync,
    input  logic                  v_sync,
    input  logic                  blank,
    input  logic [7:0]            red,
    input  logic [7:0]            green,
    input  logic [7:0]            blue,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [23:0]           write_data,
    output logic                  frame_done,
    output logic                  locked,
    output logic                  error
);

    localparam int PW = $clog2(VIEW_WIDTH + 1);
    localparam int LW = $clog2(VIEW_HEIGHT + 1);
    localparam logic [PW-1:0] PIX_FULL  = PW'(VIEW_WIDTH);
    localparam logic [LW-1:0] LINE_FULL = LW'(VIEW_HEIGHT);

    typedef enum logic [1:0] {
        SEEK,
        WAIT_ACTIVE,
        CAPTURE
    } state_t;

    state_t                state;
    logic                  h_sync_q;
    logic                  v_sync_q;
    logic                  blank_q;
    logic [23:0]           rgb_q;
    logic                  v_sync_qq;
    logic                  blank_qq;
    logic [PW-1:0]         pixel;
    logic [LW-1:0]         line;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hs_seen;
    logic                  overrun;

    logic fs;
    logic ls;
    logic le;
    logic line_mid;

    // Input register plus one extra delay stage on the signals whose edges
    // matter. Syncs reset to their idle levels so a sync held active through
    // reset is not mistaken for an edge on release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_sync_q  <= 1'b1;
            v_sync_q  <= 1'b1;
            blank_q   <= 1'b0;
            rgb_q     <= '0;
            v_sync_qq <= 1'b1;
            blank_qq  <= 1'b0;
        end else begin
            h_sync_q  <= h_sync;
            v_sync_q  <= v_sync;
            blank_q   <= blank;
            rgb_q     <= {red, green, blue};
            v_sync_qq <= v_sync_q;
            blank_qq  <= blank_q;
        end
    end

    assign fs       = v_sync_qq & ~v_sync_q;
    assign ls       = ~blank_qq & blank_q;
    assign le       = blank_qq & ~blank_q;
    assign line_mid = (line != '0) && (line < LINE_FULL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= SEEK;
            pixel         <= '0;
            line          <= '0;
            addr          <= '0;
            hs_seen       <= 1'b0;
            overrun       <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            frame_done    <= 1'b0;
            locked        <= 1'b0;
            error         <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            frame_done   <= 1'b0;
            error        <= 1'b0;

            if (!h_sync_q) begin
                hs_seen <= 1'b1;
            end else if (ls) begin
                hs_seen <= 1'b0;
            end

            case (state)
                SEEK: begin
                    if (fs) begin
                        pixel <= '0;
                        line  <= '0;
                        addr  <= '0;
                        state <= WAIT_ACTIVE;
                    end
                end

                WAIT_ACTIVE: begin
                    if (fs) begin
                        // A new frame while part-way through the old one.
                        if (line_mid) begin
                            error  <= 1'b1;
                            locked <= 1'b0;
                        end
                        pixel <= '0;
                        line  <= '0;
                        addr  <= '0;
                    end else if (ls) begin
                        if (line != '0 && !hs_seen) begin
                            error  <= 1'b1;
                            locked <= 1'b0;
                            state  <= SEEK;
                        end else begin
                            // The line-start cycle already carries pixel 0.
                            write_enable  <= 1'b1;
                            write_address <= addr;
                            write_data    <= rgb_q;
                            addr          <= addr + ADDR_WIDTH'(1);
                            pixel         <= PW'(1);
                            overrun       <= 1'b0;
                            state         <= CAPTURE;
                        end
                    end
                end

                CAPTURE: begin
                    if (fs) begin
                        // Frame restart wins; only an incomplete line is an
                        // error when the line ends in the same cycle.
                        if (!le || pixel != PIX_FULL || overrun) begin
                            error  <= 1'b1;
                            locked <= 1'b0;
                        end
                        pixel <= '0;
                        line  <= '0;
                        addr  <= '0;
                        state <= WAIT_ACTIVE;
                    end else if (le) begin
                        if (pixel == PIX_FULL && !overrun) begin
                            pixel <= '0;
                            line  <= line + LW'(1);
                            if (line + LW'(1) == LINE_FULL) begin
                                frame_done <= 1'b1;
                                locked     <= 1'b1;
                                state      <= SEEK;
                            end else begin
                                state <= WAIT_ACTIVE;
                            end
                        end else begin
                            error  <= 1'b1;
                            locked <= 1'b0;
                            state  <= SEEK;
                        end
                    end else if (blank_q) begin
                        if (pixel < PIX_FULL) begin
                            write_enable  <= 1'b1;
                            write_address <= addr;
                            write_data    <= rgb_q;
                            addr          <= addr + ADDR_WIDTH'(1);
                            pixel         <= pixel + PW'(1);
                        end else begin
                            // Pixel counter stops at the line width; remember
                            // the excess so the line-end check still fails.
                            overrun <= 1'b1;
                        end
                    end
                end

                default: state <= SEEK;
            endcase
        end
    end

endmodule
